sw_debounce: RTL and testbench



---
 rtl/board_pkg.sv | 32 +++
 rtl/sw_debounce_if.sv | 40 ++++
 rtl/sw_debounce_bit.sv | 91 +++++++++
 rtl/sw_debounce.sv | 76 +++++++
 tb/tb_sw_debounce.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// ---------------------------------------------------------------------------
// board_pkg
//
// Board-level constants shared by the switch input conditioner (sw_debounce)
// and the LED output driver (led). It also holds the small types used by the
// debounce logic.
//
// Contents:
//   CLK_HZ, DEBOUNCE_MS   - system clock rate and switch settle time
//   N_SW, N_LED           - switch and LED counts on the board
//   DEBOUNCE_CYCLES       - settle time expressed in clock cycles
//   deb_state_e           - per-bit debounce state (STABLE / PENDING)
// ---------------------------------------------------------------------------
package board_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;
    localparam int N_SW        = 8;
    localparam int N_LED       = 16;

    // With the defaults above this is 500000 cycles, i.e. 10 ms at 50 MHz.
    localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // Each bit is STABLE while its counter is idle (cnt == 0). It is PENDING
    // while the synchronized input disagrees with the debounced level and the
    // counter is still accumulating.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

endpackage : board_pkg

// File: rtl/sw_debounce_if.sv
// ---------------------------------------------------------------------------
// sw_debounce_if
//
// Bundles the switch-side signals of sw_debounce so that the pin driver (or
// a bench) and the consumer can share a single handle.
//
// Signals:
//   sw_raw      - asynchronous switch pins          (master -> slave)
//   sw          - debounced level                   (slave  -> master)
//   sw_rise     - per-bit one-cycle 0->1 strobe     (slave  -> master)
//   sw_fall     - per-bit one-cycle 1->0 strobe     (slave  -> master)
//   sw_chg      - one-cycle "any strobe" flag       (slave  -> master)
//   dbg_pending - per-bit debounce state, 1 = PENDING (slave -> master)
//
// Handshake: there is none. Every strobe is fire-and-forget and lasts
// exactly one clock, and nothing can stall the debouncer. A consumer that
// cares about edges must sample sw_rise/sw_fall/sw_chg on every clock.
// ---------------------------------------------------------------------------
interface sw_debounce_if #(
    parameter int N_SW = 8
);
    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
    logic            sw_chg;
    logic [N_SW-1:0] dbg_pending;

    // Pin side: drives the raw switches and observes the cleaned result.
    modport master (
        output sw_raw,
        input  sw, sw_rise, sw_fall, sw_chg, dbg_pending
    );

    // Debouncer side.
    modport slave (
        input  sw_raw,
        output sw, sw_rise, sw_fall, sw_chg, dbg_pending
    );
endinterface : sw_debounce_if

// File: rtl/sw_debounce_bit.sv
// ---------------------------------------------------------------------------
// sw_debounce_bit
//
// One switch bit. It contains a two-flop synchronizer, a stability counter,
// the debounced level and the registered rise/fall strobes.
//
// Ports:
//   clk, rst   - clock; synchronous active-high reset
//   sw_raw_i   - asynchronous pin
//   sw_o       - debounced level
//   rise_o     - one-cycle pulse, registered together with the 0->1 commit
//   fall_o     - one-cycle pulse, registered together with the 1->0 commit
//   evt_d_o    - next-state "commit happens on this edge". The parent uses
//                it to register an OR of all strobes in the same cycle.
//   state_o    - STABLE (cnt == 0) / PENDING (cnt > 0)
// ---------------------------------------------------------------------------
module sw_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_raw_i,
    output logic                   sw_o,
    output logic                   rise_o,
    output logic                   fall_o,
    output logic                   evt_d_o,
    output board_pkg::deb_state_e  state_o
);
    import board_pkg::*;

    // The counter counts from 0 up to DEBOUNCE_CYCLES-1, so $clog2 bits are
    // enough. DEBOUNCE_CYCLES >= 2 keeps the width at 1 bit or more.
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q,   s1_d;
    logic          s2_q,   s2_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          lvl_q,  lvl_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        s1_d   = sw_raw_i;
        s2_d   = s1_q;
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;

        if (s2_q == lvl_q) begin
            // Any agreeing cycle restarts the count, so a glitch of any
            // length shorter than DEBOUNCE_CYCLES is rejected.
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            // This is the DEBOUNCE_CYCLES-th consecutive disagreeing cycle,
            // so commit the new level.
            lvl_d  = s2_q;
            cnt_d  = '0;
            rise_d = s2_q;
            fall_d = ~s2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_o    = lvl_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign evt_d_o = rise_d | fall_d;
    assign state_o = (cnt_q != '0) ? ST_PENDING : ST_STABLE;

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//
// Input conditioner for the board slide switches. Each bit is synchronized,
// then filtered so that only a level held for DEBOUNCE_CYCLES consecutive
// synchronized cycles is accepted. The module reports the clean level and
// one-cycle rise/fall strobes.
//
// Ports:
//   clk         - system clock (50 MHz on the board)
//   rst         - synchronous active-high reset
//   sw_raw      - asynchronous switch pins [N_SW]
//   sw          - debounced level [N_SW]
//   sw_rise     - one-cycle pulse per bit on 0->1 of sw
//   sw_fall     - one-cycle pulse per bit on 1->0 of sw
//   sw_chg      - one-cycle flag, OR of sw_rise|sw_fall, same cycle
//   dbg_pending - per-bit debounce state, 1 = PENDING
//
// Latency: a level first sampled at edge E0 appears on sw at
// E(1+DEBOUNCE_CYCLES).
// ---------------------------------------------------------------------------
module sw_debounce #(
    parameter int N_SW            = board_pkg::N_SW,
    parameter int DEBOUNCE_CYCLES = board_pkg::DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            sw_chg,
    output logic [N_SW-1:0] dbg_pending
);
    import board_pkg::*;

    logic [N_SW-1:0] evt_d;
    logic            sw_chg_q, sw_chg_d;

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        deb_state_e st;

        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .sw_raw_i (sw_raw[i]),
            .sw_o     (sw[i]),
            .rise_o   (sw_rise[i]),
            .fall_o   (sw_fall[i]),
            .evt_d_o  (evt_d[i]),
            .state_o  (st)
        );

        assign dbg_pending[i] = (st == ST_PENDING);
    end

    // The OR is taken of the per-bit next-state strobes and then registered.
    // As a result sw_chg is a clean flop output that is high in exactly the
    // cycle the registered strobes are high.
    always_comb begin
        sw_chg_d = |evt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_chg_q <= 1'b0;
        end else begin
            sw_chg_q <= sw_chg_d;
        end
    end

    assign sw_chg = sw_chg_q;

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
//
// Bench for sw_debounce with N_SW=8, DEBOUNCE_CYCLES=4 and a 20 ns clock.
// The reference model works from the recorded history of synchronized
// samples. A bit commits when the last DEBOUNCE_CYCLES synchronized samples
// since its previous commit or reset all disagree with its level.
// ---------------------------------------------------------------------------
module tb_sw_debounce;
    localparam int NB  = 8;
    localparam int DEB = 4;
    localparam int HN  = 8192;

    logic clk;
    logic rst;

    sw_debounce_if #(.N_SW(NB)) bus ();

    sw_debounce #(
        .N_SW            (NB),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_raw      (bus.sw_raw),
        .sw          (bus.sw),
        .sw_rise     (bus.sw_rise),
        .sw_fall     (bus.sw_fall),
        .sw_chg      (bus.sw_chg),
        .dbg_pending (bus.dbg_pending)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;

    // Model: the synchronizer pipe, the history of synchronized samples
    // indexed by edge number, and the edge of each bit's last commit/reset.
    logic [NB-1:0] m_s1, m_s2, m_sw, m_rise, m_fall;
    logic          m_chg;
    logic [NB-1:0] hist [0:HN-1];
    int            last_ev [NB];
    int            t = 0;

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, t);
        end
    endtask

    // Apply inputs, take one edge, advance the model and compare every output.
    task automatic step(input logic [NB-1:0] raw, input logic r);
        logic [NB-1:0] commit;
        bit ok;
        bus.sw_raw = raw;
        rst        = r;
        @(posedge clk);
        t++;
        if (t >= HN) begin
            $display("FAIL history: edge budget %0d exceeded", HN);
            $fatal(1, "history overflow");
        end
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_sw = '0;
            m_rise = '0; m_fall = '0; m_chg = 1'b0;
            for (int i = 0; i < NB; i++) last_ev[i] = t;
        end else begin
            hist[t] = m_s2;
            commit  = '0;
            for (int i = 0; i < NB; i++) begin
                if (t - last_ev[i] >= DEB) begin
                    ok = 1'b1;
                    for (int k = 0; k < DEB; k++)
                        if (hist[t-k][i] == m_sw[i]) ok = 1'b0;
                    commit[i] = ok;
                end
            end
            m_rise = commit & ~m_sw;
            m_fall = commit & m_sw;
            m_sw   = m_sw ^ commit;
            m_chg  = |commit;
            for (int i = 0; i < NB; i++) if (commit[i]) last_ev[i] = t;
            m_s2 = m_s1;
            m_s1 = raw;
        end
        #1;
        check("sw",      bus.sw,      m_sw);
        check("sw_rise", bus.sw_rise, m_rise);
        check("sw_fall", bus.sw_fall, m_fall);
        check("sw_chg",  {7'b0, bus.sw_chg}, {7'b0, m_chg});
    endtask

    task automatic hold(input logic [NB-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [NB-1:0] cur;
        rst        = 1'b1;
        bus.sw_raw = '0;

        // 1. Reset with all switches high; the level arrives 6 edges later.
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b1);
        check("rst_sw", bus.sw, 8'h00);
        hold(8'hFF, 5);
        check("pre_rise", bus.sw_rise, 8'h00);
        step(8'hFF, 1'b0);
        check("rst_sw_ff",   bus.sw,      8'hFF);
        check("rst_rise_ff", bus.sw_rise, 8'hFF);
        check("rst_chg",     {7'b0, bus.sw_chg}, 8'h01);
        step(8'hFF, 1'b0);
        check("rst_rise_1cyc", bus.sw_rise, 8'h00);

        // 2. Bounce on bit 0, then settle high.
        hold(8'h00, 10);
        check("bounce_base", bus.sw, 8'h00);
        for (int p = 0; p < 10; p++) begin
            hold((p % 2 == 0) ? 8'h01 : 8'h00, 2);
            check("bounce_nostrobe", bus.sw_rise | bus.sw_fall, 8'h00);
        end
        hold(8'h01, 5);
        check("bounce_early", bus.sw_rise, 8'h00);
        step(8'h01, 1'b0);
        check("bounce_rise", bus.sw_rise, 8'h01);

        // 3. Three-cycle glitch on bit 2 is rejected.
        hold(8'h00, 10);
        hold(8'h04, 3);
        hold(8'h00, 8);
        check("glitch_sw", bus.sw, 8'h00);

        // 4. Simultaneous rise and fall.
        hold(8'h20, 10);
        check("simul_base", bus.sw, 8'h20);
        hold(8'h08, 5);
        step(8'h08, 1'b0);
        check("simul_sw",   bus.sw,      8'h08);
        check("simul_rise", bus.sw_rise, 8'h08);
        check("simul_fall", bus.sw_fall, 8'h20);
        check("simul_chg",  {7'b0, bus.sw_chg}, 8'h01);

        // 5. Reset mid-count on bit 7.
        hold(8'h00, 10);
        hold(8'h80, 3);
        step(8'h80, 1'b1);
        check("midrst_sw", bus.sw, 8'h00);
        hold(8'h80, 5);
        check("midrst_early", bus.sw, 8'h00);
        step(8'h80, 1'b0);
        check("midrst_sw80", bus.sw, 8'h80);

        // Random segments: random bit flips held for random lengths, rare resets.
        cur = 8'h80;
        for (int s = 0; s < 120; s++) begin
            cur = cur ^ NB'($urandom_range(0, 255) & $urandom_range(0, 255));
            if ($urandom_range(0, 24) == 0) step(cur, 1'b1);
            hold(cur, $urandom_range(1, 8));
        end
        hold(cur, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sw_debounce
